// File: rtl/pm_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads program memory combinationally
// and hands registered instruction words to decode over a valid/ready handshake.
module pm_fetch_ctrl #(
   parameter int                 ADDR_W   = 5,
   parameter int                 DATA_W   = 6,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(0),
   parameter logic [ADDR_W-1:0]  END_ADR  = ADDR_W'(31)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] pm_adr,
   input  logic [DATA_W-1:0] pm_data,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              jmp_en,
   input  logic [ADDR_W-1:0] jmp_adr,
   input  logic              run,
   input  logic              halt_req,
   output logic              halted
);

   typedef enum logic {ST_STOP, ST_RUN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic [DATA_W-1:0] instr_nxt;
   logic [ADDR_W-1:0] instr_pc_nxt;
   logic              instr_valid_nxt;
   logic              fetch;

   assign pm_adr = pc;
   assign halted = (state == ST_STOP) && !instr_valid;

   // The output register may refill on the same edge it is consumed.
   assign fetch = (state == ST_RUN) && (!instr_valid || instr_ready);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_nxt       = state;
      pc_nxt          = pc;
      instr_nxt       = instr;
      instr_pc_nxt    = instr_pc;
      instr_valid_nxt = instr_valid;

      case (state)
         ST_STOP: if (run && !halt_req) state_nxt = ST_RUN;
         ST_RUN:  if (halt_req)         state_nxt = ST_STOP;
         default:                       state_nxt = ST_STOP;
      endcase

      // A redirect flushes the pending word and outranks fetch and consume.
      if (jmp_en) begin
         pc_nxt          = jmp_adr;
         instr_valid_nxt = 1'b0;
      end else if (fetch) begin
         instr_nxt       = pm_data;
         instr_pc_nxt    = pc;
         instr_valid_nxt = 1'b1;
         pc_nxt          = (pc == END_ADR) ? RESET_PC : pc + ADDR_W'(1);
      end else if (instr_valid && instr_ready) begin
         instr_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         state       <= ST_STOP;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         instr       <= instr_nxt;
         instr_pc    <= instr_pc_nxt;
         instr_valid <= instr_valid_nxt;
      end
   end

endmodule
